// File: rtl/stage_sequencer_if.sv
// Handshake and status bundle between the stage sequencer and the rest of the core.
// The slave side is the sequencer; the master side is the memories and control unit.
interface stage_sequencer_if #(
   parameter int CNT_W = 16
);
   logic [5:0]       opcode;
   logic             imem_ready;
   logic             dmem_ready;
   logic             resume;
   logic [2:0]       stage;
   logic             imem_req;
   logic             ir_load;
   logic             dmem_req;
   logic             write_pc;
   logic             halted;
   logic             bus_error;
   logic [CNT_W-1:0] retired;

   modport master (
      output opcode, imem_ready, dmem_ready, resume,
      input  stage, imem_req, ir_load, dmem_req, write_pc, halted, bus_error, retired
   );

   modport slave (
      input  opcode, imem_ready, dmem_ready, resume,
      output stage, imem_req, ir_load, dmem_req, write_pc, halted, bus_error, retired
   );
endinterface

// File: rtl/stage_sequencer.sv
// Multicycle IFH/ID/EX/MEM/WB sequencer for the MUSA core with HALT, memory stalls,
// memory timeout (sticky bus error) and resume. Owns the single advance-PC strobe.
module stage_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst,
   stage_sequencer_if.slave   bus
);
   typedef enum logic [2:0] {
      S_IFH  = 3'b000,
      S_ID   = 3'b001,
      S_EX   = 3'b010,
      S_MEM  = 3'b011,
      S_WB   = 3'b100,
      S_HALT = 3'b101
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
   localparam logic [5:0] OP_NOP    = 6'b000001;
   localparam logic [5:0] OP_HALT   = 6'b000010;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;

   state_t           state_reg;
   state_t           state_next;
   logic [7:0]       wait_reg;
   logic [5:0]       opcode_q_reg;
   logic             bus_error_reg;
   logic [CNT_W-1:0] retired_reg;
   logic             imem_req_reg;
   logic             dmem_req_reg;
   logic             write_pc_reg;
   logic             halted_reg;
   logic             set_error;
   logic             clear_error;

   always_comb begin
      state_next  = S_IFH;
      set_error   = 1'b0;
      clear_error = 1'b0;
      case (state_reg)
         S_IFH: begin
            // Ready on the timeout cycle still counts as a successful fetch.
            if (bus.imem_ready) begin
               state_next = S_ID;
            end else if (wait_reg == WAIT_LAST) begin
               state_next = S_HALT;
               set_error  = 1'b1;
            end else begin
               state_next = S_IFH;
            end
         end
         S_ID: begin
            if (bus.opcode == OP_HALT) begin
               state_next = S_HALT;
            end else if (bus.opcode == OP_NOP) begin
               state_next = S_WB;
            end else begin
               state_next = S_EX;
            end
         end
         S_EX: begin
            if (opcode_q_reg == OP_LW || opcode_q_reg == OP_SW) begin
               state_next = S_MEM;
            end else begin
               state_next = S_WB;
            end
         end
         S_MEM: begin
            if (bus.dmem_ready) begin
               state_next = S_WB;
            end else if (wait_reg == WAIT_LAST) begin
               state_next = S_HALT;
               set_error  = 1'b1;
            end else begin
               state_next = S_MEM;
            end
         end
         S_WB: begin
            state_next = S_IFH;
         end
         S_HALT: begin
            // After a bus error the faulting fetch/access is retried, so PC stays put.
            if (bus.resume) begin
               if (bus_error_reg) begin
                  state_next  = S_IFH;
                  clear_error = 1'b1;
               end else begin
                  state_next = S_WB;
               end
            end else begin
               state_next = S_HALT;
            end
         end
         default: begin
            state_next = S_IFH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_IFH;
         wait_reg      <= 8'd0;
         opcode_q_reg  <= 6'd0;
         bus_error_reg <= 1'b0;
         retired_reg   <= '0;
         imem_req_reg  <= 1'b1;
         dmem_req_reg  <= 1'b0;
         write_pc_reg  <= 1'b0;
         halted_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;

         // Staying in IFH or MEM implies ready was low this cycle.
         if (state_next != state_reg) begin
            wait_reg <= 8'd0;
         end else if (state_reg == S_IFH || state_reg == S_MEM) begin
            wait_reg <= wait_reg + 8'd1;
         end

         if (state_reg == S_ID) begin
            opcode_q_reg <= bus.opcode;
         end

         if (set_error) begin
            bus_error_reg <= 1'b1;
         end else if (clear_error) begin
            bus_error_reg <= 1'b0;
         end

         if (state_reg == S_WB) begin
            retired_reg <= retired_reg + 1'b1;
         end

         imem_req_reg <= (state_next == S_IFH);
         dmem_req_reg <= (state_next == S_MEM);
         write_pc_reg <= (state_next == S_WB);
         halted_reg   <= (state_next == S_HALT);
      end
   end

   assign bus.stage     = state_reg;
   assign bus.imem_req  = imem_req_reg;
   assign bus.ir_load   = (state_reg == S_IFH) && bus.imem_ready;
   assign bus.dmem_req  = dmem_req_reg;
   assign bus.write_pc  = write_pc_reg;
   assign bus.halted    = halted_reg;
   assign bus.bus_error = bus_error_reg;
   assign bus.retired   = retired_reg;
endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: a per-cycle vector table plus hand sequences
// for asynchronous reset mid-stall and retired-counter wrap with nops.
module tb_stage_sequencer;
   localparam logic [5:0] ALU = 6'b000000;
   localparam logic [5:0] NOP = 6'b000001;
   localparam logic [5:0] HLT = 6'b000010;
   localparam logic [5:0] LW  = 6'b100011;
   localparam logic [5:0] SW  = 6'b101011;
   localparam logic [5:0] UNK = 6'b111111;

   typedef struct {
      logic [5:0] op;
      logic       ir;
      logic       dr;
      logic       res;
      logic [2:0] st;
      logic       be;
      logic [3:0] ret;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   vec_t vq[$];

   stage_sequencer_if #(.CNT_W(4)) bus ();

   stage_sequencer #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic [5:0] op, logic ir, logic dr, logic res,
                               logic [2:0] st, logic be, logic [3:0] ret);
      vec_t v;
      v.op = op; v.ir = ir; v.dr = dr; v.res = res;
      v.st = st; v.be = be; v.ret = ret;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   function automatic logic [12:0] observed();
      return {bus.stage, bus.imem_req, bus.ir_load, bus.dmem_req, bus.write_pc,
              bus.halted, bus.bus_error, bus.retired};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [12:0] exp;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.opcode = ALU;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b1;
      bus.resume = 1'b0;

      // op, imem_ready, dmem_ready, resume | stage, bus_error, retired (pre-edge)
      vq.push_back(mk(ALU,1,1,0, 3'd0,0,4'd0));
      vq.push_back(mk(ALU,1,1,0, 3'd1,0,4'd0));
      vq.push_back(mk(ALU,1,1,0, 3'd2,0,4'd0));
      vq.push_back(mk(ALU,1,1,0, 3'd4,0,4'd0));
      vq.push_back(mk(LW ,1,0,0, 3'd0,0,4'd1));
      vq.push_back(mk(LW ,1,0,0, 3'd1,0,4'd1));
      vq.push_back(mk(LW ,1,0,0, 3'd2,0,4'd1));
      vq.push_back(mk(LW ,1,0,0, 3'd3,0,4'd1));
      vq.push_back(mk(LW ,1,0,0, 3'd3,0,4'd1));
      vq.push_back(mk(LW ,1,0,0, 3'd3,0,4'd1));
      vq.push_back(mk(LW ,1,1,0, 3'd3,0,4'd1));
      vq.push_back(mk(LW ,1,1,0, 3'd4,0,4'd1));
      vq.push_back(mk(SW ,1,1,0, 3'd0,0,4'd2));
      vq.push_back(mk(SW ,1,1,0, 3'd1,0,4'd2));
      vq.push_back(mk(SW ,1,1,0, 3'd2,0,4'd2));
      vq.push_back(mk(SW ,1,1,0, 3'd3,0,4'd2));
      vq.push_back(mk(SW ,1,1,0, 3'd4,0,4'd2));
      vq.push_back(mk(HLT,1,1,0, 3'd0,0,4'd3));
      vq.push_back(mk(HLT,1,1,0, 3'd1,0,4'd3));
      vq.push_back(mk(HLT,0,1,0, 3'd5,0,4'd3));
      vq.push_back(mk(HLT,0,1,0, 3'd5,0,4'd3));
      vq.push_back(mk(HLT,0,1,1, 3'd5,0,4'd3));
      vq.push_back(mk(HLT,0,1,0, 3'd4,0,4'd3));
      vq.push_back(mk(NOP,0,1,0, 3'd0,0,4'd4));
      vq.push_back(mk(NOP,0,1,0, 3'd0,0,4'd4));
      vq.push_back(mk(NOP,1,1,0, 3'd0,0,4'd4));
      vq.push_back(mk(NOP,1,1,0, 3'd1,0,4'd4));
      vq.push_back(mk(NOP,1,1,0, 3'd4,0,4'd4));
      vq.push_back(mk(ALU,0,1,0, 3'd0,0,4'd5));
      vq.push_back(mk(ALU,0,1,0, 3'd0,0,4'd5));
      vq.push_back(mk(ALU,0,1,0, 3'd0,0,4'd5));
      vq.push_back(mk(ALU,0,1,0, 3'd0,0,4'd5));
      vq.push_back(mk(ALU,0,1,0, 3'd5,1,4'd5));
      vq.push_back(mk(ALU,0,1,1, 3'd5,1,4'd5));
      vq.push_back(mk(ALU,1,1,0, 3'd0,0,4'd5));
      vq.push_back(mk(ALU,1,1,0, 3'd1,0,4'd5));
      vq.push_back(mk(ALU,1,1,0, 3'd2,0,4'd5));
      vq.push_back(mk(ALU,1,1,0, 3'd4,0,4'd5));
      vq.push_back(mk(LW ,1,0,0, 3'd0,0,4'd6));
      vq.push_back(mk(LW ,1,0,0, 3'd1,0,4'd6));
      vq.push_back(mk(LW ,1,0,0, 3'd2,0,4'd6));
      vq.push_back(mk(LW ,1,0,0, 3'd3,0,4'd6));
      vq.push_back(mk(LW ,1,0,0, 3'd3,0,4'd6));
      vq.push_back(mk(LW ,1,0,0, 3'd3,0,4'd6));
      vq.push_back(mk(LW ,1,0,0, 3'd3,0,4'd6));
      vq.push_back(mk(LW ,1,0,1, 3'd5,1,4'd6));
      vq.push_back(mk(UNK,1,1,0, 3'd0,0,4'd6));
      vq.push_back(mk(UNK,1,1,0, 3'd1,0,4'd6));
      vq.push_back(mk(UNK,1,1,0, 3'd2,0,4'd6));
      vq.push_back(mk(UNK,1,1,0, 3'd4,0,4'd6));
      vq.push_back(mk(LW ,1,0,0, 3'd0,0,4'd7));

      // Reset state, and ir_load tracking imem_ready while reset is held.
      #2;
      check("reset_outputs_ir0", 32'(observed()), 32'({3'd0, 1'b1, 1'b0, 4'b0000, 4'd0}));
      bus.imem_ready = 1'b1;
      #1;
      check("reset_ir_load_follows", 32'(bus.ir_load), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         bus.opcode     = vq[i].op;
         bus.imem_ready = vq[i].ir;
         bus.dmem_ready = vq[i].dr;
         bus.resume     = vq[i].res;
         #1;
         exp = {vq[i].st, vq[i].st == 3'd0, (vq[i].st == 3'd0) && vq[i].ir,
                vq[i].st == 3'd3, vq[i].st == 3'd4, vq[i].st == 3'd5,
                vq[i].be, vq[i].ret};
         check($sformatf("vec%0d", i), 32'(observed()), 32'(exp));
         tick();
      end

      // Drive the pending lw into a MEM stall, then reset between clock edges.
      bus.opcode = LW;
      bus.dmem_ready = 1'b0;
      #1;
      tick();
      tick();
      tick();
      check("mid_mem_stage", 32'(bus.stage), 32'd3);
      check("mid_mem_dmem_req", 32'(bus.dmem_req), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_stage", 32'(bus.stage), 32'd0);
      check("async_rst_dmem_req", 32'(bus.dmem_req), 32'd0);
      check("async_rst_imem_req", 32'(bus.imem_req), 32'd1);
      check("async_rst_retired", 32'(bus.retired), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Sixteen nops: IFH, ID, WB each, retired wraps 15 -> 0.
      bus.opcode = NOP;
      bus.imem_ready = 1'b1;
      bus.dmem_ready = 1'b1;
      #1;
      for (int n = 0; n < 16; n++) begin
         check($sformatf("nop%0d_ifh", n), 32'(bus.stage), 32'd0);
         tick();
         check($sformatf("nop%0d_id", n), 32'(bus.stage), 32'd1);
         tick();
         check($sformatf("nop%0d_wb", n), 32'({bus.stage, bus.write_pc}), 32'({3'd4, 1'b1}));
         tick();
         check($sformatf("nop%0d_retired", n), 32'(bus.retired), 32'((n + 1) % 16));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Multicycle stage sequencer for the MUSA core. Steps each instruction through IFH, ID, EX, MEM and WB.
- Generates the stage code that drives the microprogrammed control unit's per-stage decode, plus the memory request handshakes and the single-cycle PC write.
- Handles HALT, memory-wait stalls, memory timeouts and resume.
- Sits between the instruction/data memories and the control unit; owns the only "advance PC" strobe in the core.

Parameters:
- MEM_TIMEOUT, 15: max cycles spent in IFH or MEM waiting for ready before bus error; legal range 1..255.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  opcode field of the instruction register; valid from the ID cycle onward.
- imem_ready  in  1  instruction memory has data this cycle.
- dmem_ready  in  1  data memory access completes this cycle.
- resume  in  1  leave HALT (level sampled on the rising edge).
- stage  out  3  current stage: 000 IFH, 001 ID, 010 EX, 011 MEM, 100 WB, 101 HALT.
- imem_req  out  1  high while in IFH.
- ir_load  out  1  combinational: IFH and imem_ready; loads the instruction register.
- dmem_req  out  1  high while in MEM.
- write_pc  out  1  high for exactly the one WB cycle.
- halted  out  1  high while in HALT.
- bus_error  out  1  sticky memory-timeout flag.
- retired  out  CNT_W  count of instructions that completed WB; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, any cycle, including mid-stall):
  - state = IFH, wait counter = 0, opcode_q = 0, bus_error = 0, retired = 0.
  - Therefore stage = 000, imem_req = 1, and dmem_req, write_pc and halted are 0.
  - ir_load follows imem_ready immediately.
- Outputs other than ir_load are decoded from registered state only (Moore).
- Wait counter (8 bit): cleared on every state change; increments each cycle spent in IFH or MEM without ready.
- IFH:
  - imem_ready = 1 → ID, wait counter cleared.
  - Otherwise, when wait counter == MEM_TIMEOUT-1 → HALT with bus_error set.
  - Otherwise stay in IFH.
- ID: capture opcode into opcode_q; next state chosen from the live opcode:
  - 000010 (halt) → HALT.
  - 000001 (nop) → WB; skips EX and MEM.
  - anything else → EX.
- EX:
  - opcode_q is 100011 (lw) or 101011 (sw) → MEM.
  - else → WB; covers r_type, immediates, jr, jpc, brfl, call, ret and unknown opcodes.
- MEM: same ready/timeout rule as IFH, using dmem_ready; completion → WB.
- WB: write_pc = 1; retired increments by 1; → IFH unconditionally.
- HALT:
  - resume = 1 with bus_error = 0 → WB, so PC advances past the halt instruction.
  - resume = 1 with bus_error = 1 → clear bus_error, → IFH, re-fetch; PC is not advanced.
  - resume = 0 → stay in HALT.
- Stage-entry rules:
  - ready already high on the first cycle of IFH/MEM: that stage lasts exactly 1 cycle.
  - ready arriving on the timeout cycle: ready wins, no error.
- Latencies:
  - ALU instruction: 4 cycles (IFH ID EX WB).
  - lw/sw with zero wait: 5 cycles.
  - nop: 3 cycles.
- Unused state encodings 110 and 111 → IFH on the next edge.

Test Plan:
- Reset sequencing: rst pulse, imem_ready = dmem_ready = 1, opcode = 000000 → stage sequence 000,001,010,100,000; write_pc high only in the 100 cycle; retired = 1 after the first WB.
- lw with memory stalls: opcode = 100011, dmem_ready held low 3 cycles then high → MEM lasts 4 cycles, dmem_req high throughout; 8 cycles from IFH entry to WB exit.
- Halt and resume: opcode = 000010 → HALT after ID, halted = 1, retired unchanged. Resume pulse → WB next cycle, write_pc = 1, retired +1, then IFH.
- Timeout: MEM_TIMEOUT = 4, imem_ready held 0 → HALT after 4 IFH cycles, bus_error = 1. Resume → IFH, bus_error = 0, no write_pc.
- Reset mid-MEM: assert rst during a MEM stall → stage = 000 and dmem_req = 0 without waiting for a clock edge; retired = 0.
- Counter wrap and nop: CNT_W = 4, run 16 nop instructions → retired wraps 15 → 0; each nop takes exactly 3 cycles.
